// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
//
// Purpose:
//   Bundles every handshake/bus signal of the instruction fetch unit into one
//   interface: the instruction-memory request channel, the instruction stream
//   presented to the decode/execute stage, and the redirect request coming
//   back from the datapath.
//
// Signal summary:
//   imem_req     fetch unit -> memory   request, held until imem_ack
//   imem_addr    fetch unit -> memory   request address, stable while imem_req
//   imem_ack     memory -> fetch unit   imem_rdata valid this cycle
//   imem_rdata   memory -> fetch unit   fetched instruction word
//   instr_out    fetch unit -> datapath FIFO head instruction
//   instr_pc     fetch unit -> datapath address of instr_out
//   instr_valid  fetch unit -> datapath FIFO non-empty
//   instr_ready  datapath -> fetch unit head consumed when valid & ready
//   redirect_en  datapath -> fetch unit control-flow change
//   redirect_pc  datapath -> fetch unit new fetch target
//
// Modports:
//   master : the fetch unit itself
//   slave  : the environment (instruction memory + datapath)
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 19
);
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    logic [INSTR_WIDTH-1:0] instr_out;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_valid;
    logic                   instr_ready;

    logic                   redirect_en;
    logic [ADDR_WIDTH-1:0]  redirect_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr_out,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect_en,
        input  redirect_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect_en,
        output redirect_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Fetches INSTR_WIDTH-bit instructions from a wait-stated instruction memory
//   into a DEPTH-entry prefetch FIFO and presents one instruction per cycle,
//   together with its PC, to the decode/execute stage. Redirects from the
//   datapath flush the prefetched words and restart fetching at the new PC.
//
// Ports:
//   clk     in  system clock, all state updates on the rising edge
//   rst     in  synchronous, active-high reset
//   io_bus  master modport of instruction_fetch_unit_if
//           (imem_req/imem_addr/imem_ack/imem_rdata,
//            instr_out/instr_pc/instr_valid/instr_ready,
//            redirect_en/redirect_pc)
//
// Operation:
//   IDLE : no request outstanding; starts one when a FIFO slot will be free.
//   REQ  : request for r_fetch_pc outstanding; an ack pushes {word, pc}.
//   DROP : a redirect arrived while a request was still waiting. The memory
//          still owns that request, so its address is held on imem_addr until
//          the ack arrives, and the returned word is thrown away.
//   Only one request is ever outstanding.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_fetch_unit_if.master io_bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_hold_addr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_next;
    logic [ADDR_WIDTH-1:0] w_hold_addr_next;
    logic [CNT_W-1:0]      w_count_next;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_has_room;
    logic                  w_not_empty;

    logic [INSTR_WIDTH-1:0] w_slot_instr [DEPTH];
    logic [ADDR_WIDTH-1:0]  w_slot_pc    [DEPTH];

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    assign w_not_empty = (r_count != '0);
    assign w_flush     = io_bus.redirect_en;

    // The datapath may consume the head even in a redirect cycle; the flush
    // then simply wins over the pointer/count update.
    assign w_pop  = w_not_empty & io_bus.instr_ready;

    // Only an ack for a live (non-stale) request with no redirect pending
    // delivers a useful word.
    assign w_push = (r_state == ST_REQ) & io_bus.imem_ack & ~io_bus.redirect_en;

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // A new request is only launched while a slot is guaranteed free, which
    // keeps the count bounded by DEPTH.
    assign w_has_room = (w_count_next < CNT_W'(DEPTH));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_fetch_pc_next  = r_fetch_pc;
        w_hold_addr_next = r_hold_addr;

        case (r_state)
            ST_IDLE: begin
                if (io_bus.redirect_en) begin
                    w_fetch_pc_next = io_bus.redirect_pc;
                    w_state_next    = ST_REQ;
                end else if (w_has_room) begin
                    w_state_next = ST_REQ;
                end
            end

            ST_REQ: begin
                if (io_bus.imem_ack) begin
                    if (io_bus.redirect_en) begin
                        // Returned word belongs to the old path: drop it and
                        // issue the new target right away.
                        w_fetch_pc_next = io_bus.redirect_pc;
                    end else begin
                        // Natural wrap at 2^ADDR_WIDTH.
                        w_fetch_pc_next = r_fetch_pc + ADDR_WIDTH'(1);
                        if (!w_has_room) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end else if (io_bus.redirect_en) begin
                    // Request still in flight: keep presenting its address
                    // until the memory answers.
                    w_hold_addr_next = r_fetch_pc;
                    w_fetch_pc_next  = io_bus.redirect_pc;
                    w_state_next     = ST_DROP;
                end
            end

            ST_DROP: begin
                if (io_bus.redirect_en) begin
                    w_fetch_pc_next = io_bus.redirect_pc;
                end
                if (io_bus.imem_ack) begin
                    w_state_next = ST_REQ;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fetch_pc  <= '0;
            r_hold_addr <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_fetch_pc  <= w_fetch_pc_next;
            r_hold_addr <= w_hold_addr_next;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= w_count_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: one {instr, pc} register pair per slot.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [INSTR_WIDTH-1:0] r_instr;
            logic [ADDR_WIDTH-1:0]  r_pc;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_instr <= '0;
                    r_pc    <= '0;
                end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_instr <= io_bus.imem_rdata;
                    r_pc    <= r_fetch_pc;
                end
            end

            assign w_slot_instr[gi] = r_instr;
            assign w_slot_pc[gi]    = r_pc;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_bus.imem_req  = (r_state == ST_REQ) | (r_state == ST_DROP);
    assign io_bus.imem_addr = (r_state == ST_DROP) ? r_hold_addr :
                              (r_state == ST_REQ)  ? r_fetch_pc  : '0;

    // Head is read combinationally; forced to zero while empty so stale
    // slot contents never leak onto the datapath inputs.
    assign io_bus.instr_valid = w_not_empty;
    assign io_bus.instr_out   = w_not_empty ? w_slot_instr[r_rd_ptr] : '0;
    assign io_bus.instr_pc    = w_not_empty ? w_slot_pc[r_rd_ptr]    : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Drives the fetch unit with a wait-stated memory model, a randomly ready
// datapath and redirects. A queue-based reference model tracks which PCs
// must sit in the prefetch buffer, which address must be on the memory bus,
// and whether the outstanding request is stale after a redirect.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;
    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int IW    = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    instruction_fetch_unit #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Environment settings and reference model state
    // ------------------------------------------------------------------
    bit            scramble;
    int            wait_min, wait_max, ready_pct;
    int            req_age, req_wait, cyc;
    logic [AW-1:0] mq[$];          // PCs expected in the prefetch buffer
    logic [AW-1:0] consumed[$];    // PCs taken by the datapath
    logic [AW-1:0] m_fetch_pc, m_stale_addr, prev_addr;
    bit            m_stale, prev_wait;

    function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
        if (scramble) return {a[6:0] ^ 7'h5A, a ^ 12'hC3C};
        return {7'b0, a};
    endfunction

    function automatic logic [31:0] consumed_at(input int i);
        if (consumed.size() > i) return 32'(consumed[i]);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fetch_pc = '0;
        m_stale    = 1'b0;
        prev_wait  = 1'b0;
        req_age    = 0;
        req_wait   = 0;
        cyc        = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_imem_req"},    bus.imem_req,    1'b0);
        check_eq({tag, "_imem_addr"},   bus.imem_addr,   '0);
        check_eq({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
        check_eq({tag, "_instr_out"},   bus.instr_out,   '0);
        check_eq({tag, "_instr_pc"},    bus.instr_pc,    '0);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: called #1 after a rising edge. Checks outputs against
    // the model, drives this cycle's inputs, advances the model, waits an edge.
    task automatic step(input bit redir, input logic [AW-1:0] rpc);
        logic          req, valid, ack, rdy;
        logic [AW-1:0] addr, pc;
        logic [IW-1:0] instr;
        req   = bus.imem_req;
        addr  = bus.imem_addr;
        valid = bus.instr_valid;
        pc    = bus.instr_pc;
        instr = bus.instr_out;

        check_eq("instr_valid", valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check_eq("head_pc", pc, mq[0]);
            check_eq("head_instr", instr, word_at(mq[0]));
        end
        if (m_stale) check_eq("req_while_stale", req, 1'b1);
        if (req) check_eq("imem_addr", addr, m_stale ? m_stale_addr : m_fetch_pc);
        if (prev_wait) begin
            check_eq("req_held", req, 1'b1);
            check_eq("addr_stable", addr, prev_addr);
        end
        if (mq.size() == DEPTH && !m_stale) check_eq("req_when_full", req, 1'b0);

        rdy = (int'($urandom_range(0, 99)) < ready_pct);
        ack = 1'b0;
        if (req) begin
            if (req_age == 0) req_wait = int'($urandom_range(wait_min, wait_max));
            ack = (req_age >= req_wait);
        end
        bus.instr_ready = rdy;
        bus.imem_ack    = ack;
        bus.imem_rdata  = ack ? word_at(addr) : IW'($urandom);
        bus.redirect_en = redir;
        bus.redirect_pc = rpc;

        if (rdy && mq.size() != 0) begin
            consumed.push_back(mq[0]);
            $display("  cyc=%0d consume pc=%03h instr=%05h", cyc, pc, instr);
            void'(mq.pop_front());
        end
        if (redir) begin
            mq.delete();
            if (req && !ack) begin
                if (!m_stale) begin
                    m_stale      = 1'b1;
                    m_stale_addr = m_fetch_pc;
                end
            end else if (req && ack) begin
                m_stale = 1'b0;
            end
            m_fetch_pc = rpc;
        end else if (req && ack) begin
            if (m_stale) begin
                m_stale = 1'b0;
            end else begin
                mq.push_back(m_fetch_pc);
                m_fetch_pc = m_fetch_pc + 1'b1;
            end
        end

        if (req) req_age = ack ? 0 : req_age + 1;
        else     req_age = 0;
        prev_wait = req && !ack;
        prev_addr = addr;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  first_valid;
        bit  found;

        // ---- 1: zero-wait memory, plain words, always ready -------------
        scramble = 1'b0; wait_min = 0; wait_max = 0; ready_pct = 100;
        do_reset();
        consumed.delete();
        first_valid = -1;
        for (int c = 1; c <= 30; c++) begin
            step(1'b0, '0);
            if (first_valid < 0 && bus.instr_valid) first_valid = c;
            if (first_valid >= 0) check_eq("stream_valid", bus.instr_valid, 1'b1);
        end
        check_eq("first_valid_cycle", first_valid, 2);
        check_eq("stream_count", consumed.size(), 28);
        check_eq("stream_pc0", consumed_at(0), 0);
        check_eq("stream_pc27", consumed_at(27), 27);

        // ---- 2: 2 wait states, datapath stalled: FIFO fills -------------
        scramble = 1'b1; wait_min = 2; wait_max = 2; ready_pct = 0;
        do_reset();
        consumed.delete();
        run(20);
        for (int i = 0; i < 5; i++) begin
            check_eq("full_req_low", bus.imem_req, 1'b0);
            check_eq("full_head_pc", bus.instr_pc, 0);
            step(1'b0, '0);
        end
        ready_pct = 100;
        run(30);
        for (int i = 0; i < 5; i++) check_eq("drain_pc", consumed_at(i), i);

        // ---- 3: redirect while waiting on addr 5 ------------------------
        wait_min = 3; wait_max = 3; ready_pct = 100;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bus.imem_req && bus.imem_addr == 12'd5 && req_age == 0) found = 1'b1;
            else step(1'b0, '0);
        end
        check_eq("reach_addr5", found, 1'b1);
        step(1'b1, 12'h100);
        consumed.delete();
        check_eq("drop_addr_held", bus.imem_addr, 12'd5);
        run(40);
        check_eq("redir_first_pc", consumed_at(0), 12'h100);
        check_eq("redir_second_pc", consumed_at(1), 12'h101);

        // ---- 4: redirect coinciding with ack of addr 7 and a pop --------
        wait_min = 0; wait_max = 0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bus.imem_req && bus.imem_addr == 12'd7 && bus.instr_valid) found = 1'b1;
            else step(1'b0, '0);
        end
        check_eq("reach_addr7", found, 1'b1);
        step(1'b1, 12'h020);
        consumed.delete();
        check_eq("flush_valid_low", bus.instr_valid, 1'b0);
        run(20);
        check_eq("ack_redir_first_pc", consumed_at(0), 12'h020);

        // ---- 5: redirect near the top of the address space (wrap) -------
        step(1'b1, 12'hFFE);
        consumed.delete();
        run(20);
        check_eq("wrap_pc0", consumed_at(0), 12'hFFE);
        check_eq("wrap_pc1", consumed_at(1), 12'hFFF);
        check_eq("wrap_pc2", consumed_at(2), 12'h000);
        check_eq("wrap_pc3", consumed_at(3), 12'h001);

        // ---- 6: reset while in DROP, late ack afterwards -----------------
        wait_min = 3; wait_max = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bus.imem_req && req_age == 0 && cyc > 6) found = 1'b1;
            else step(1'b0, '0);
        end
        check_eq("reach_wait", found, 1'b1);
        step(1'b1, 12'h300);
        check_eq("drop_req", bus.imem_req, 1'b1);
        check_eq("drop_addr", bus.imem_addr, m_stale_addr);
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.redirect_en = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("drop_reset");
        rst = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 19'h7FFFF;
        @(posedge clk); #1;
        check_eq("late_ack_not_pushed", bus.instr_valid, 1'b0);
        check_eq("restart_req", bus.imem_req, 1'b1);
        check_eq("restart_addr", bus.imem_addr, 12'h000);
        model_reset();
        consumed.delete();
        run(20);
        check_eq("restart_first_pc", consumed_at(0), 12'h000);

        // ---- 7: randomized traffic ---------------------------------------
        do_reset();
        consumed.delete();
        for (int blk = 0; blk < 15; blk++) begin
            wait_min  = int'($urandom_range(0, 2));
            wait_max  = wait_min + int'($urandom_range(0, 2));
            ready_pct = int'($urandom_range(20, 100));
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 99) < 4)
                    step(1'b1, ($urandom_range(0, 3) == 0) ? AW'($urandom_range(4090, 4095))
                                                           : AW'($urandom));
                else
                    step(1'b0, '0);
            end
        end
        check_eq("random_progress", consumed.size() > 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
